// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types, constants and helpers for the UART receive tap.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_e;

  // Clock cycles per bit, truncating integer division.
  function automatic int uart_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : First-word-fall-through byte FIFO. A push into a full FIFO is
//                accepted only when a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   level;
  logic [7:0]    last_rd;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (level == (AW+1)'(DEPTH));
  assign empty_o = (level == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign level_o = level;
  // While empty the output keeps showing the byte most recently read.
  assign data_o  = empty_o ? last_rd : mem[rptr];

  // Storage write; contents need no reset because the output is masked while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= data_i;
  end

  // Pointers, occupancy and last-read byte.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      last_rd <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) begin
        rptr    <= rptr + 1'b1;
        last_rd <= mem[rptr];
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_tap.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_tap
//  Description : 8N1 UART receiver tapping a TX line, with FWFT byte buffer,
//                valid/ready output stream, frame-error and overrun pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_tap
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          rx_i,
  output logic [7:0]                    rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic                          frame_err_o,
  output logic                          overrun_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int DIV  = uart_div(CLK_HZ, BAUD);
  localparam int HALF = DIV / 2;
  localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_rx_state_e state, state_nxt;

  logic          sync1;
  logic          rxs;
  logic          rxs_d;
  logic          fell;
  logic [CW-1:0] cnt;
  logic          cnt_clr;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          shift_en;
  logic          push_req;
  logic          ferr_set;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          frame_err_q;
  logic          overrun_q;

  assign fell        = rxs_d && !rxs;
  assign rx_valid_o  = !fifo_empty;
  assign pop         = rx_valid_o && rx_ready_i;
  assign busy_o      = (state != IDLE);
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection; idle-high reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rx_i;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic and per-cycle sample/push/error strobes.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    push_req  = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (fell) state_nxt = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_clr   = 1'b1;
          state_nxt = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == CNT_FULL) begin
          cnt_clr = 1'b1;
          if (rxs) begin
            push_req  = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_set  = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_clr = 1'b1;
        if (rxs) state_nxt = IDLE;
      end
      default: begin
        cnt_clr   = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  // Bit-period counter, cleared on every sample and state entry.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else              cnt <= cnt + 1'b1;
  end

  // LSB-first shift register and data-bit counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (state == START) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      shreg   <= {rxs, shreg[7:1]};
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Registered error pulses, aligned to the cycle after the stop sample.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= ferr_set;
      overrun_q   <= push_req && fifo_full && !pop;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push_req),
    .data_i  (shreg),
    .pop_i   (pop),
    .data_o  (rx_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_tap.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_tap
//  Description : Self-checking bench for uart_rx_tap with a queue-based model
//                of the received byte stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_tap;

  localparam int CLK_HZ = 25000000;
  localparam int BAUD   = 1000000;
  localparam int DEPTH  = 16;
  localparam int BIT_T  = CLK_HZ / BAUD;
  localparam int HALF_T = BIT_T / 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       ovr;
  logic       busy;
  logic [4:0] level;

  always #5 clk = ~clk;

  uart_rx_tap #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .rx_i         (rx),
    .rx_data_o    (data),
    .rx_valid_o   (valid),
    .rx_ready_i   (ready),
    .frame_err_o  (ferr),
    .overrun_o    (ovr),
    .busy_o       (busy),
    .fifo_level_o (level)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] model_q[$];
  int ferr_seen  = 0;
  int ovr_seen   = 0;
  int exp_ovr    = 0;
  int popped     = 0;
  int cyc        = 0;
  int last_fall  = 0;
  int rise_cyc   = -1;
  bit arm_rise   = 1'b0;
  bit rand_ready = 1'b0;
  logic valid_d  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Free-running cycle counter for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: count pulses, time first valid, check every popped byte against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ferr) ferr_seen++;
      if (ovr)  ovr_seen++;
      if (arm_rise && valid && !valid_d && rise_cyc < 0) rise_cyc = cyc;
      if (valid && ready) begin
        chk("pop_model_nonempty", 32'(model_q.size() != 0), 32'd1);
        if (model_q.size() != 0) chk("pop_data", 32'(data), 32'(model_q.pop_front()));
        popped++;
      end
    end
    valid_d = valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) ready = 1'($urandom_range(0, 1));
  endtask

  // Transmit one 8N1 frame; the model learns the byte as the stop bit begins.
  task automatic send(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    last_fall = cyc;
    repeat (BIT_T) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_T) tick();
    end
    if (stop) begin
      if (model_q.size() < DEPTH) model_q.push_back(b);
      else exp_ovr++;
    end
    rx = stop;
    repeat (BIT_T) tick();
    rx = 1'b1;
  endtask

  task automatic drain();
    ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH && valid; i++) tick();
    ready = 1'b0;
    tick();
  endtask

  initial begin
    int f0;
    int o0;
    int p0;
    logic [7:0] b;

    // Reset values
    tick(); tick(); tick();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data",  32'(data),  32'd0);
    chk("rst_ferr",  32'(ferr),  32'd0);
    chk("rst_ovr",   32'(ovr),   32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_level", 32'(level), 32'd0);
    rst_n = 1'b1;
    repeat (2 * BIT_T) tick();

    // Single byte, latency and one pop
    arm_rise = 1'b1;
    send(8'h55, 1'b1);
    arm_rise = 1'b0;
    chk("latency",   32'(rise_cyc - last_fall), 32'(2 + HALF_T + 9 * BIT_T + 1));
    chk("b55_valid", 32'(valid), 32'd1);
    chk("b55_data",  32'(data),  32'h55);
    chk("b55_level", 32'(level), 32'd1);
    chk("b55_flags", 32'(ferr_seen + ovr_seen), 32'd0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    chk("b55_level_after_pop", 32'(level), 32'd0);
    chk("b55_popped", 32'(popped), 32'd1);

    // Back-to-back frames, then a consecutive three-cycle drain
    send(8'h48, 1'b1);
    send(8'h69, 1'b1);
    send(8'h0A, 1'b1);
    chk("b2b_level", 32'(level), 32'd3);
    ready = 1'b1;
    repeat (3) tick();
    ready = 1'b0;
    chk("b2b_valid_after", 32'(valid), 32'd0);
    chk("b2b_popped", 32'(popped), 32'd4);

    // False start: short low pulse
    f0 = ferr_seen;
    rx = 1'b0;
    repeat (HALF_T / 2) tick();
    chk("fs_busy_high", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (HALF_T + 4 - HALF_T / 2) tick();
    chk("fs_busy_low", 32'(busy), 32'd0);
    repeat (BIT_T) tick();
    chk("fs_level", 32'(level), 32'd0);
    chk("fs_no_ferr", 32'(ferr_seen - f0), 32'd0);

    // Bad stop bit followed by a held-low line
    f0 = ferr_seen;
    send(8'hA5, 1'b0);
    rx = 1'b0;
    repeat (30 * BIT_T) tick();
    rx = 1'b1;
    repeat (2 * BIT_T) tick();
    chk("fe_one_pulse", 32'(ferr_seen - f0), 32'd1);
    chk("fe_level", 32'(level), 32'd0);
    chk("fe_busy", 32'(busy), 32'd0);
    p0 = popped;
    send(8'h3C, 1'b1);
    drain();
    chk("fe_recover_popped", 32'(popped - p0), 32'd1);

    // Overrun on the 17th byte
    o0 = ovr_seen;
    for (int i = 0; i < 16; i++) send(8'(i), 1'b1);
    chk("ov_level_full", 32'(level), 32'd16);
    chk("ov_none_yet", 32'(ovr_seen - o0), 32'd0);
    exp_ovr = 0;
    send(8'h10, 1'b1);
    chk("ov_one_pulse", 32'(ovr_seen - o0), 32'(exp_ovr));
    chk("ov_level_still_full", 32'(level), 32'd16);
    p0 = popped;
    drain();
    chk("ov_drained", 32'(popped - p0), 32'd16);
    chk("ov_level_empty", 32'(level), 32'd0);

    // Randomized bytes, gaps and consumer back-pressure
    f0 = ferr_seen;
    o0 = ovr_seen;
    p0 = popped;
    rand_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      send(b, 1'b1);
      repeat ($urandom_range(0, 2) * BIT_T) tick();
    end
    rand_ready = 1'b0;
    ready = 1'b0;
    tick();
    drain();
    chk("rnd_all_popped", 32'(popped - p0), 32'd12);
    chk("rnd_model_empty", 32'(model_q.size()), 32'd0);
    chk("rnd_no_flags", 32'((ferr_seen - f0) + (ovr_seen - o0)), 32'd0);

    // Reset in the middle of a data bit, with the FIFO holding a byte
    send(8'h11, 1'b1);
    chk("mr_pre_valid", 32'(valid), 32'd1);
    b = 8'h81;
    rx = 1'b0;
    repeat (BIT_T) tick();
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      repeat (BIT_T) tick();
    end
    rx = b[3];
    repeat (HALF_T) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(valid), 32'd0);
    chk("mr_data",  32'(data),  32'd0);
    chk("mr_busy",  32'(busy),  32'd0);
    chk("mr_level", 32'(level), 32'd0);
    chk("mr_flags", 32'({ferr, ovr}), 32'd0);
    model_q.delete();
    rx = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2 * BIT_T) tick();
    p0 = popped;
    send(8'h7E, 1'b1);
    chk("mr_7e_data", 32'(data), 32'h7E);
    drain();
    chk("mr_7e_popped", 32'(popped - p0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
